// File: rtl/error_report_responder_pkg.sv
// Shared types and default MMIO addresses for the error report responder.
package CAPI_PKG;

    // Handshake states of the error reporting FSM.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        ACK        = 2'd2,
        WAIT_CLEAR = 2'd3
    } err_state_e;

    // Default MMIO word addresses.
    localparam logic [0:23] DEF_ERROR_REG_ADDR = 24'h3FFF8;
    localparam logic [0:23] DEF_ERROR_CNT_ADDR = 24'h3FFF0;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/error_report_responder_mmio_decode.sv
// MMIO address decode and registered one-cycle read-response path.
module error_mmio_decode
    import CAPI_PKG::*;
#(
    parameter logic [0:23] ERROR_REG_ADDR = DEF_ERROR_REG_ADDR,
    parameter logic [0:23] ERROR_CNT_ADDR = DEF_ERROR_CNT_ADDR
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_read_i,
    input  logic [0:23] req_addr_i,
    input  logic [0:63] err_latched_i,
    input  logic [15:0] err_count_i,
    input  logic        timeout_flag_i,
    output logic        rd_err_reg_o,
    output logic        wr_cnt_reg_o,
    output logic        rsp_valid_o,
    output logic [0:63] rsp_data_o
);

    logic        hit_err;
    logic        hit_cnt;
    logic        rd_cnt_reg;
    logic        rsp_valid_q, rsp_valid_d;
    logic [0:63] rsp_data_q, rsp_data_d;

    // Decode the request and select the pre-update register value to return.
    always_comb begin
        hit_err      = req_valid_i && (req_addr_i == ERROR_REG_ADDR);
        hit_cnt      = req_valid_i && (req_addr_i == ERROR_CNT_ADDR);
        rd_err_reg_o = hit_err && req_read_i;
        rd_cnt_reg   = hit_cnt && req_read_i;
        wr_cnt_reg_o = hit_cnt && !req_read_i;
        rsp_valid_d  = rd_err_reg_o || rd_cnt_reg;
        rsp_data_d   = '0;
        if (rd_err_reg_o) begin
            rsp_data_d = err_latched_i;
        end else if (rd_cnt_reg) begin
            rsp_data_d = {timeout_flag_i, 47'd0, err_count_i};
        end
    end

    // Response register; data is forced to zero whenever no response is valid.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/error_report_responder.sv
// Latches error reports, raises an interrupt until the host reads them,
// acknowledges the report and waits for the error-control block to clear.
module error_report_responder
    import CAPI_PKG::*;
#(
    parameter logic [0:23] ERROR_REG_ADDR = DEF_ERROR_REG_ADDR,
    parameter logic [0:23] ERROR_CNT_ADDR = DEF_ERROR_CNT_ADDR,
    parameter logic [7:0]  CLEAR_TIMEOUT  = 8'd255
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [0:63] report_errors,
    input  logic        reset_error,
    input  logic        mmio_req_valid,
    input  logic        mmio_req_read,
    input  logic [0:23] mmio_req_addr,
    output logic        report_errors_ack,
    output logic        mmio_rsp_valid,
    output logic [0:63] mmio_rsp_data,
    output logic        err_interrupt
);

    err_state_e  state_q, state_d;
    logic [0:63] err_latched_q, err_latched_d;
    logic [15:0] err_count_q, err_count_d;
    logic [7:0]  timer_q, timer_d;
    logic        timeout_flag_q, timeout_flag_d;
    logic        rd_err_reg;
    logic        wr_cnt_reg;
    logic        capture;
    logic        timeout_exit;

    error_mmio_decode #(
        .ERROR_REG_ADDR (ERROR_REG_ADDR),
        .ERROR_CNT_ADDR (ERROR_CNT_ADDR)
    ) u_mmio (
        .clock          (clock),
        .rst            (rst),
        .req_valid_i    (mmio_req_valid),
        .req_read_i     (mmio_req_read),
        .req_addr_i     (mmio_req_addr),
        .err_latched_i  (err_latched_q),
        .err_count_i    (err_count_q),
        .timeout_flag_i (timeout_flag_q),
        .rd_err_reg_o   (rd_err_reg),
        .wr_cnt_reg_o   (wr_cnt_reg),
        .rsp_valid_o    (mmio_rsp_valid),
        .rsp_data_o     (mmio_rsp_data)
    );

    // State and data registers; reset aborts any handshake in progress.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            err_latched_q  <= '0;
            err_count_q    <= '0;
            timer_q        <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_latched_q  <= err_latched_d;
            err_count_q    <= err_count_d;
            timer_q        <= timer_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // Next-state logic, register updates and state-decoded outputs.
    always_comb begin
        state_d           = state_q;
        err_latched_d     = err_latched_q;
        err_count_d       = err_count_q;
        timer_d           = timer_q;
        timeout_flag_d    = timeout_flag_q;
        capture           = 1'b0;
        timeout_exit      = 1'b0;
        err_interrupt     = 1'b0;
        report_errors_ack = 1'b0;

        case (state_q)
            IDLE: begin
                if (|report_errors) begin
                    err_latched_d = report_errors;
                    capture       = 1'b1;
                    state_d       = PENDING;
                end
            end
            PENDING: begin
                err_interrupt = 1'b1;
                err_latched_d = err_latched_q | report_errors;
                if (rd_err_reg) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                report_errors_ack = 1'b1;
                timer_d           = '0;
                state_d           = WAIT_CLEAR;
            end
            WAIT_CLEAR: begin
                // The explicit clear request wins over a simultaneous timeout.
                if (!reset_error) begin
                    err_latched_d = '0;
                    state_d       = IDLE;
                end else if (timer_q == CLEAR_TIMEOUT) begin
                    err_latched_d = '0;
                    timeout_exit  = 1'b1;
                    state_d       = IDLE;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A host clear of the count still records a capture in the same cycle.
        if (wr_cnt_reg) begin
            err_count_d = capture ? 16'd1 : 16'd0;
        end else if (capture) begin
            err_count_d = sat_inc16(err_count_q);
        end

        if (timeout_exit) begin
            timeout_flag_d = 1'b1;
        end
        if (wr_cnt_reg) begin
            timeout_flag_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_error_report_responder.sv
// Directed bench with a response scoreboard for error_report_responder.
module tb_error_report_responder;

    localparam logic [0:23] A_ERR = 24'h3FFF8;
    localparam logic [0:23] A_CNT = 24'h3FFF0;
    localparam logic [0:23] A_BAD = 24'h00010;

    logic        clock;
    logic        rst;
    logic [0:63] report_errors;
    logic        reset_error;
    logic        mmio_req_valid;
    logic        mmio_req_read;
    logic [0:23] mmio_req_addr;
    logic        report_errors_ack;
    logic        mmio_rsp_valid;
    logic [0:63] mmio_rsp_data;
    logic        err_interrupt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    error_report_responder dut (
        .clock             (clock),
        .rst               (rst),
        .report_errors     (report_errors),
        .reset_error       (reset_error),
        .mmio_req_valid    (mmio_req_valid),
        .mmio_req_read     (mmio_req_read),
        .mmio_req_addr     (mmio_req_addr),
        .report_errors_ack (report_errors_ack),
        .mmio_rsp_valid    (mmio_rsp_valid),
        .mmio_rsp_data     (mmio_rsp_data),
        .err_interrupt     (err_interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mmio(input logic rd, input logic [0:23] addr);
        $display("mmio %s addr=%h", rd ? "read " : "write", addr);
        mmio_req_valid = 1'b1;
        mmio_req_read  = rd;
        mmio_req_addr  = addr;
        tick();
        mmio_req_valid = 1'b0;
        mmio_req_read  = 1'b0;
        mmio_req_addr  = '0;
    endtask

    task automatic rd_expect(input logic [0:23] addr, input logic [63:0] exp);
        exp_q.push_back(exp);
        $display("expect read addr=%h data=%h", addr, exp);
        mmio(1'b1, addr);
    endtask

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clock) begin
        if (!rst) begin
            if (mmio_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got data %h with no read outstanding", mmio_rsp_data);
                end else begin
                    check("rsp_data", mmio_rsp_data, exp_q.pop_front());
                end
            end else begin
                check("idle_rsp_data_zero", mmio_rsp_data, 64'h0);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        report_errors  = '0;
        reset_error    = 1'b1;
        mmio_req_valid = 1'b0;
        mmio_req_read  = 1'b0;
        mmio_req_addr  = '0;
        repeat (3) tick();
        check("rst_ack", report_errors_ack, 0);
        check("rst_irq", err_interrupt, 0);
        check("rst_rsp_valid", mmio_rsp_valid, 0);
        rst = 1'b0;
        tick();

        // Basic capture, read and acknowledge.
        report_errors = 64'h5;
        tick();
        report_errors = '0;
        check("irq_after_capture", err_interrupt, 1);
        rd_expect(A_ERR, 64'h5);
        check("ack_pulse", report_errors_ack, 1);
        tick();
        check("ack_one_cycle", report_errors_ack, 0);
        check("irq_off_after_read", err_interrupt, 0);
        reset_error = 1'b0;
        tick();
        reset_error = 1'b1;
        rd_expect(A_CNT, 64'h1);
        mmio(1'b0, A_CNT);
        rd_expect(A_CNT, 64'h0);

        // OR-accumulation while pending, then the clear timeout.
        report_errors = 64'h1;
        tick();
        report_errors = 64'h8;
        tick();
        report_errors = '0;
        rd_expect(A_ERR, 64'h9);
        check("ack_pulse2", report_errors_ack, 1);
        tick();
        report_errors = 64'hF0;
        tick();
        report_errors = '0;
        repeat (254) tick();
        rd_expect(A_CNT, 64'h1);
        rd_expect(A_CNT, 64'h8000_0000_0000_0001);
        rd_expect(A_ERR, 64'h0);
        check("irq_idle_after_timeout", err_interrupt, 0);

        // Count saturation and clear.
        mmio(1'b0, A_CNT);
        rd_expect(A_CNT, 64'h0);
        force dut.err_count_q = 16'hFFFF;
        tick();
        release dut.err_count_q;
        report_errors = 64'h2;
        tick();
        report_errors = '0;
        rd_expect(A_CNT, 64'hFFFF);
        rd_expect(A_ERR, 64'h2);
        tick();
        reset_error = 1'b0;
        tick();
        reset_error = 1'b1;
        mmio(1'b0, A_CNT);
        rd_expect(A_CNT, 64'h0);

        // Count clear coinciding with a capture ends at one.
        report_errors = 64'h4;
        mmio(1'b0, A_CNT);
        report_errors = '0;
        rd_expect(A_CNT, 64'h1);
        rd_expect(A_ERR, 64'h4);
        tick();
        reset_error = 1'b0;
        tick();
        reset_error = 1'b1;

        // Unmapped accesses and writes to the error register are ignored.
        mmio(1'b1, A_BAD);
        mmio(1'b0, A_ERR);
        mmio(1'b0, A_BAD);
        tick();
        check("no_rsp_unmapped", mmio_rsp_valid, 0);

        // Read coinciding with capture returns the old value; reset aborts ACK.
        report_errors = 64'h7;
        rd_expect(A_ERR, 64'h0);
        report_errors = '0;
        check("irq_capture7", err_interrupt, 1);
        rd_expect(A_CNT, 64'h2);
        mmio_req_valid = 1'b1;
        mmio_req_read  = 1'b1;
        mmio_req_addr  = A_ERR;
        @(posedge clock);
        #1;
        mmio_req_valid = 1'b0;
        mmio_req_read  = 1'b0;
        mmio_req_addr  = '0;
        $display("read addr=%h then reset asserted in ACK", A_ERR);
        check("ack_before_rst", report_errors_ack, 1);
        check("rsp_before_rst", mmio_rsp_data, 64'h7);
        rst = 1'b1;
        #1;
        check("ack_async_rst", report_errors_ack, 0);
        check("rsp_valid_async_rst", mmio_rsp_valid, 0);
        check("rsp_data_async_rst", mmio_rsp_data, 64'h0);
        check("irq_async_rst", err_interrupt, 0);
        check("count_async_rst", dut.err_count_q, 0);
        check("latched_async_rst", dut.err_latched_q, 0);
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        rd_expect(A_CNT, 64'h0);
        rd_expect(A_ERR, 64'h0);
        check("irq_after_rst", err_interrupt, 0);

        repeat (3) tick();
        check("pending_responses", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
